wb_port_arbiter: RTL and testbench

- Shares the register file's single write port between NUM_SRC writeback sources (e.g. ALU, LSU, MUL/DIV).
- Each source has a valid/ready handshake. One source wins per cycle by round-robin.
- The winner is captured in a one-entry output stage that drives we/rd_addr/rd_data into register_file.
- Sits between the execute/memory units and the WB write port. Also reports backpressure statistics.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/wb_port_arbiter.sv | 88 ++++++++
 tb/tb_wb_port_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core types and writeback request definitions
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;
    localparam int NUM_WB_SRC = 3;

    typedef logic [XLEN-1:0]              xlen_t;
    typedef logic [$clog2(REG_COUNT)-1:0] reg_addr_t;

    typedef struct packed {
        logic [4:0] rd_addr;
        xlen_t      rd_data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at rr_ptr
module rr_arbiter #(
    parameter int  NUM_REQ = 3,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    localparam int SW = IDX_W + 1;

    logic [SW-1:0] sum;

    // Scan from the farthest offset down so the closest valid request to rr_ptr wins.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        sum       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + SW'(k);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            if (en && req[sum[IDX_W-1:0]]) begin
                gnt_idx   = sum[IDX_W-1:0];
                gnt_valid = 1'b1;
            end
        end
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin sharing of the register file write port
module wb_port_arbiter
    import riscv_pkg::*;
#(
    parameter int NUM_SRC = NUM_WB_SRC,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  reg_addr_t [NUM_SRC-1:0]  src_rd_addr,
    input  xlen_t [NUM_SRC-1:0]      src_rd_data,
    output logic [NUM_SRC-1:0]       src_ready,
    input  logic                     wb_stall,
    output logic                     we,
    output logic [4:0]               rd_addr,
    output xlen_t                    rd_data,
    output logic                     out_busy,
    output logic [CNT_W-1:0]         conflict_cnt
);

    localparam int IDX_W = $clog2(NUM_SRC);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             can_accept;
    logic             arb_en;
    logic             conflict;
    logic             out_valid_q, out_valid_d;
    wb_req_t          out_q, out_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    // The stage drains on every unstalled cycle, so it only blocks while frozen and full.
    assign can_accept = !out_valid_q || !wb_stall;
    assign arb_en     = can_accept && !rst;

    rr_arbiter #(.NUM_REQ(NUM_SRC)) u_rr (
        .req       (src_valid),
        .en        (arb_en),
        .rr_ptr    (rr_ptr_q),
        .gnt       (src_ready),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign conflict = |(src_valid & ~src_ready);

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        out_valid_d    = out_valid_q;
        out_d          = out_q;
        conflict_cnt_d = conflict_cnt_q;
        if (gnt_valid) begin
            rr_ptr_d      = (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + IDX_W'(1);
            out_valid_d   = 1'b1;
            out_d.rd_addr = src_rd_addr[gnt_idx];
            out_d.rd_data = src_rd_data[gnt_idx];
        end else if (!wb_stall) begin
            out_valid_d = 1'b0;
        end
        if (conflict && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            out_valid_q    <= 1'b0;
            out_q          <= '0;
            conflict_cnt_q <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            out_valid_q    <= out_valid_d;
            out_q          <= out_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Writes to x0 still occupy the stage but never reach the register file.
    assign we           = out_valid_q && !wb_stall && (out_q.rd_addr != 5'd0);
    assign rd_addr      = out_q.rd_addr;
    assign rd_data      = out_q.rd_data;
    assign out_busy     = out_valid_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed checks of arbitration, stall, x0, reset and saturation
module tb_wb_port_arbiter;
    import riscv_pkg::*;

    logic clk;
    logic rst;

    logic [2:0]       a_valid;
    reg_addr_t [2:0]  a_addr;
    xlen_t [2:0]      a_data;
    logic [2:0]       a_ready;
    logic             a_stall;
    logic             a_we;
    logic [4:0]       a_rd_addr;
    xlen_t            a_rd_data;
    logic             a_busy;
    logic [15:0]      a_cnt;

    logic [2:0]       b_valid;
    reg_addr_t [2:0]  b_addr;
    xlen_t [2:0]      b_data;
    logic [2:0]       b_ready;
    logic             b_stall;
    logic             b_we;
    logic [4:0]       b_rd_addr;
    xlen_t            b_rd_data;
    logic             b_busy;
    logic [3:0]       b_cnt;

    int n_cmp;
    int n_bad;

    wb_port_arbiter #(.NUM_SRC(3), .CNT_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (a_valid),
        .src_rd_addr  (a_addr),
        .src_rd_data  (a_data),
        .src_ready    (a_ready),
        .wb_stall     (a_stall),
        .we           (a_we),
        .rd_addr      (a_rd_addr),
        .rd_data      (a_rd_data),
        .out_busy     (a_busy),
        .conflict_cnt (a_cnt)
    );

    wb_port_arbiter #(.NUM_SRC(3), .CNT_W(4)) u_dut_sat (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (b_valid),
        .src_rd_addr  (b_addr),
        .src_rd_data  (b_data),
        .src_ready    (b_ready),
        .wb_stall     (b_stall),
        .we           (b_we),
        .rd_addr      (b_rd_addr),
        .rd_data      (b_rd_data),
        .out_busy     (b_busy),
        .conflict_cnt (b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        a_valid = '0;
        a_addr  = '0;
        a_data  = '0;
        a_stall = 1'b0;
        b_valid = '0;
        b_addr  = '0;
        b_data  = '0;
        b_stall = 1'b0;
        #3;
        check_eq("rst_we", a_we, 0);
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_cnt", a_cnt, 0);
        check_eq("rst_ready", a_ready, 0);
        check_eq("rst_addr", a_rd_addr, 0);
        check_eq("rst_data", a_rd_data, 0);
        tick();
        rst = 1'b0;

        // single source, one-cycle latency
        a_valid   = 3'b001;
        a_addr[0] = 5'd5;
        a_data[0] = 32'hDEAD_BEEF;
        #1;
        check_eq("single_ready", a_ready, 3'b001);
        tick();
        a_valid = '0;
        #1;
        check_eq("single_we", a_we, 1);
        check_eq("single_addr", a_rd_addr, 5);
        check_eq("single_data", a_rd_data, 32'hDEAD_BEEF);
        check_eq("single_ready_off", a_ready, 0);
        tick();
        #1;
        check_eq("single_we_off", a_we, 0);
        check_eq("single_busy_off", a_busy, 0);
        check_eq("single_cnt", a_cnt, 0);

        // all three valid from reset: rotation 0,1,2,0,1,2
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_addr[i] = reg_addr_t'(i + 1);
            a_data[i] = xlen_t'(32'h100 + i);
        end
        a_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            check_eq($sformatf("rr_ready_c%0d", c), a_ready, 3'b001 << (c % 3));
            if (c == 2) check_eq("rr_cnt_after3", a_cnt, 2);
            if (c >= 1) begin
                check_eq($sformatf("rr_we_c%0d", c), a_we, 1);
                check_eq($sformatf("rr_addr_c%0d", c), a_rd_addr, ((c - 1) % 3) + 1);
            end
            tick();
        end
        a_valid = '0;
        #1;
        check_eq("rr_last_we", a_we, 1);
        check_eq("rr_last_addr", a_rd_addr, 3);
        check_eq("rr_last_data", a_rd_data, 32'h102);
        check_eq("rr_cnt_total", a_cnt, 6);
        tick();
        #1;
        check_eq("rr_drain_we", a_we, 0);

        // x0 write consumes a slot without asserting we
        a_valid   = 3'b010;
        a_addr[1] = 5'd0;
        a_data[1] = 32'h1234;
        #1;
        check_eq("x0_ready", a_ready, 3'b010);
        tick();
        a_valid = '0;
        #1;
        check_eq("x0_busy", a_busy, 1);
        check_eq("x0_we", a_we, 0);
        check_eq("x0_data", a_rd_data, 32'h1234);
        tick();
        #1;
        check_eq("x0_busy_off", a_busy, 0);

        // stall holds addr 7 while src0 waits, then both move on the release cycle
        a_valid   = 3'b100;
        a_addr[2] = 5'd7;
        a_data[2] = 32'h77;
        #1;
        check_eq("stall_load_ready", a_ready, 3'b100);
        tick();
        a_valid   = 3'b001;
        a_addr[0] = 5'd9;
        a_data[0] = 32'h99;
        a_stall   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq($sformatf("stall_we_c%0d", c), a_we, 0);
            check_eq($sformatf("stall_ready_c%0d", c), a_ready, 0);
            check_eq($sformatf("stall_addr_c%0d", c), a_rd_addr, 7);
            tick();
        end
        a_stall = 1'b0;
        #1;
        check_eq("unstall_we", a_we, 1);
        check_eq("unstall_addr", a_rd_addr, 7);
        check_eq("unstall_ready", a_ready, 3'b001);
        check_eq("unstall_cnt", a_cnt, 10);
        tick();
        a_valid = '0;
        #1;
        check_eq("after_stall_we", a_we, 1);
        check_eq("after_stall_addr", a_rd_addr, 9);
        check_eq("after_stall_data", a_rd_data, 32'h99);
        tick();

        // stall with empty stage takes one entry then blocks
        a_stall   = 1'b1;
        a_valid   = 3'b010;
        a_addr[1] = 5'd4;
        a_data[1] = 32'h44;
        #1;
        check_eq("stall_empty_ready", a_ready, 3'b010);
        tick();
        a_valid   = 3'b110;
        a_addr[1] = 5'd11;
        a_data[1] = 32'hBB;
        #1;
        check_eq("stall_full_ready", a_ready, 0);
        check_eq("stall_full_busy", a_busy, 1);
        check_eq("stall_full_we", a_we, 0);
        check_eq("stall_full_addr", a_rd_addr, 4);

        // reset while busy and stalled
        rst = 1'b1;
        #1;
        check_eq("midrst_we", a_we, 0);
        check_eq("midrst_busy", a_busy, 0);
        check_eq("midrst_cnt", a_cnt, 0);
        check_eq("midrst_ready", a_ready, 0);
        check_eq("midrst_addr", a_rd_addr, 0);
        rst = 1'b0;
        #1;
        check_eq("postrst_ready", a_ready, 3'b010);
        tick();
        a_valid = 3'b100;
        a_stall = 1'b0;
        #1;
        check_eq("postrst_we", a_we, 1);
        check_eq("postrst_addr", a_rd_addr, 11);
        check_eq("postrst_ready2", a_ready, 3'b100);
        tick();
        a_valid = '0;
        tick();

        // saturation of a 4-bit counter
        b_valid = 3'b011;
        #1;
        check_eq("sat_first_ready", b_ready, 3'b001);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) check_eq("sat_cnt_14", b_cnt, 14);
            if (k == 20) check_eq("sat_cnt_20", b_cnt, 15);
        end
        b_valid = '0;
        tick();
        #1;
        check_eq("sat_cnt_hold", b_cnt, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
